// File: rtl/object_reporter.sv
// Purpose : sweeps the labeller's per-label object table after a frame and streams
//           out one record per label whose area reaches the latched threshold.
// Latency : 2+READ_LATENCY cycles per skipped label, 3+READ_LATENCY per emitted label
//           (with rec_ready high); done pulses one cycle after the last label.
// Backpressure: a pending record holds rec_* stable and stalls the sweep until rec_ready.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 one-cycle pulse requesting a sweep (ignored while busy or on done)
//   num_labels, min_area  sweep bounds and area threshold, latched on an accepted start
//   obj_id -> obj_x/obj_y/obj_area   table lookup; data valid READ_LATENCY cycles after obj_id
//   rec_valid/rec_ready, rec_label/rec_x/rec_y/rec_area   output record stream
//   busy, done, obj_count sweep status; obj_count holds the last sweep's record count

module object_reporter #(
    parameter int WORD_SIZE    = 8,
    parameter int LOC_SIZE     = 10,
    parameter int OBJ_WIDTH    = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_labels,
    input  logic [OBJ_WIDTH-1:0] min_area,
    output logic [WORD_SIZE-1:0] obj_id,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    input  logic [OBJ_WIDTH-1:0] obj_area,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [WORD_SIZE-1:0] rec_label,
    output logic [LOC_SIZE-1:0]  rec_x,
    output logic [LOC_SIZE-1:0]  rec_y,
    output logic [OBJ_WIDTH-1:0] rec_area,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] obj_count
);

    // WAIT counts down from READ_LATENCY-1 to 0; the capture happens on the 0 cycle.
    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [WORD_SIZE-1:0]   r_last;
    logic [OBJ_WIDTH-1:0]   r_thr;
    logic [1:0]             r_wait_cnt;

    // A zero area means the label was merged away or never written; its centroid
    // came from a divide-by-zero, so it is never reported even with a zero threshold.
    logic w_keep;
    assign w_keep = (obj_area != '0) && (obj_area >= r_thr);

    // The done cycle is spent in IDLE, so a start there must be masked explicitly.
    logic w_start_ok;
    assign w_start_ok = start && !done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last     <= '0;
            r_thr      <= '0;
            r_wait_cnt <= '0;
            obj_id     <= '0;
            rec_valid  <= 1'b0;
            rec_label  <= '0;
            rec_x      <= '0;
            rec_y      <= '0;
            rec_area   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            obj_count  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_last    <= num_labels - WORD_SIZE'(1);
                        r_thr     <= min_area;
                        obj_count <= '0;
                        busy      <= 1'b1;
                        // num_labels of 0 or 1 means no valid labels: go straight to DONE.
                        if (num_labels > WORD_SIZE'(1)) begin
                            obj_id  <= WORD_SIZE'(1);
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= WAIT_INIT;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        rec_label <= obj_id;
                        rec_x     <= obj_x;
                        rec_y     <= obj_y;
                        rec_area  <= obj_area;
                        if (w_keep) begin
                            rec_valid <= 1'b1;
                            r_state   <= S_EMIT;
                        end else begin
                            r_state   <= S_NEXT;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        if (obj_count != '1) begin
                            obj_count <= obj_count + WORD_SIZE'(1);
                        end
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    // Compare before incrementing so obj_id never wraps past the last label.
                    if (obj_id == r_last) begin
                        r_state <= S_DONE;
                    end else begin
                        obj_id  <= obj_id + WORD_SIZE'(1);
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    obj_id  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_object_reporter.sv
// Bench for object_reporter: two instances (READ_LATENCY 1 and 3) run the same
// directed scenarios in parallel against a table model with exact read latency.

module tb_object_reporter;

    localparam int NI = 2;

    typedef struct packed {
        logic [7:0]  label;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] area;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start_s   [NI];
    logic [7:0]  nl_s      [NI];
    logic [15:0] thr_s     [NI];
    logic        rdy_s     [NI];
    logic [7:0]  obj_id    [NI];
    logic [9:0]  obj_x     [NI];
    logic [9:0]  obj_y     [NI];
    logic [15:0] obj_area  [NI];
    logic        rec_valid [NI];
    logic [7:0]  rec_label [NI];
    logic [9:0]  rec_x     [NI];
    logic [9:0]  rec_y     [NI];
    logic [15:0] rec_area  [NI];
    logic        busy      [NI];
    logic        done      [NI];
    logic [7:0]  obj_count [NI];

    // Object table seen by the DUTs
    logic [9:0]  tbl_x    [256];
    logic [9:0]  tbl_y    [256];
    logic [15:0] tbl_area [256];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int RL = (g == 0) ? 1 : 3;
        logic [7:0] hist [4];

        object_reporter #(
            .WORD_SIZE(8), .LOC_SIZE(10), .OBJ_WIDTH(16), .READ_LATENCY(RL)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start_s[g]),
            .num_labels(nl_s[g]), .min_area(thr_s[g]),
            .obj_id(obj_id[g]), .obj_x(obj_x[g]), .obj_y(obj_y[g]), .obj_area(obj_area[g]),
            .rec_valid(rec_valid[g]), .rec_ready(rdy_s[g]),
            .rec_label(rec_label[g]), .rec_x(rec_x[g]), .rec_y(rec_y[g]), .rec_area(rec_area[g]),
            .busy(busy[g]), .done(done[g]), .obj_count(obj_count[g])
        );

        // Table answers exactly RL cycles after obj_id changes; earlier it shows the old label.
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < 4; i++) hist[i] <= 8'd0;
            end else begin
                hist[0] <= obj_id[g];
                for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            end
        end
        assign obj_x[g]    = tbl_x[hist[RL-1]];
        assign obj_y[g]    = tbl_y[hist[RL-1]];
        assign obj_area[g] = tbl_area[hist[RL-1]];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- model ----------------
    rec_t exp_list [256];
    int   exp_n;
    int   exp_last;
    int   head      [NI];
    int   done_cnt  [NI];
    logic prev_stall[NI];
    rec_t prev_rec  [NI];
    int   last_cyc  [NI];
    int   last_lbl  [NI];
    bit   spacing_en;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void build_expected(input int nl, input int thr);
        exp_last = (nl == 0) ? 0 : nl - 1;
        exp_n = 0;
        for (int id = 1; id <= exp_last; id++) begin
            if (tbl_area[id] != 16'd0 && int'(tbl_area[id]) >= thr) begin
                exp_list[exp_n] = {8'(id), tbl_x[id], tbl_y[id], tbl_area[id]};
                exp_n++;
            end
        end
    endfunction

    function automatic rec_t cur_rec(input int k);
        return {rec_label[k], rec_x[k], rec_y[k], rec_area[k]};
    endfunction

    function automatic int rl_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Compare process: record order/content, stall stability, done status, cadence.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!reset_n) begin
                prev_stall[k] = 1'b0;
            end else begin
                check($sformatf("obj_id range[%0d]", k), obj_id[k] <= 8'(exp_last), 1);
                if (prev_stall[k]) begin
                    check($sformatf("stall valid[%0d]", k), rec_valid[k], 1);
                    check($sformatf("stall rec[%0d]", k), cur_rec(k), prev_rec[k]);
                end
                if (rec_valid[k] && rdy_s[k]) begin
                    if (head[k] < exp_n) begin
                        check($sformatf("record %0d[%0d]", head[k], k), cur_rec(k), exp_list[head[k]]);
                        if (spacing_en && head[k] > 0 && int'(rec_label[k]) == last_lbl[k] + 1)
                            check($sformatf("cadence[%0d]", k), cyc - last_cyc[k], 3 + rl_of(k));
                        head[k]++;
                    end else begin
                        check($sformatf("extra record[%0d]", k), cur_rec(k), 0);
                        n_pass -= (cur_rec(k) === 0) ? 1 : 0;
                    end
                    last_cyc[k] = cyc;
                    last_lbl[k] = int'(rec_label[k]);
                end
                if (done[k]) begin
                    check($sformatf("done all out[%0d]", k), head[k], exp_n);
                    check($sformatf("done count[%0d]", k), obj_count[k], (exp_n > 255) ? 255 : exp_n);
                    check($sformatf("done busy[%0d]", k), busy[k], 0);
                    done_cnt[k]++;
                end
                prev_stall[k] = rec_valid[k] && !rdy_s[k];
                prev_rec[k]   = cur_rec(k);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_pulse(input int k, input int nl, input int thr);
        head[k]    = 0;
        start_s[k] = 1'b1;
        nl_s[k]    = 8'(nl);
        thr_s[k]   = 16'(thr);
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        // Scramble inputs after the start: only the latched values may matter.
        nl_s[k]    = 8'd2;
        thr_s[k]   = 16'hFFFF;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done[k]) break;
            n++;
        end
        if (n >= budget) fail($sformatf("wait done[%0d]", k));
    endtask

    task automatic wait_valid(input int k, input int budget);
        int n = 0;
        while (n < budget && !rec_valid[k]) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail($sformatf("wait valid[%0d]", k));
    endtask

    task automatic t_basic(input int k);
        start_pulse(k, 4, 5);
        wait_done(k, 200);
        check($sformatf("basic count[%0d]", k), obj_count[k], 2);
    endtask

    task automatic t_bp(input int k);
        start_pulse(k, 4, 5);
        wait_valid(k, 100);
        check($sformatf("bp valid 0[%0d]", k), rec_valid[k], 1);
        check($sformatf("bp label 0[%0d]", k), rec_label[k], 1);
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("bp valid %0d[%0d]", i, k), rec_valid[k], 1);
            check($sformatf("bp label %0d[%0d]", i, k), rec_label[k], 1);
        end
        @(posedge clk); #1;
        rdy_s[k] = 1'b1;
        wait_done(k, 200);
        check($sformatf("bp count[%0d]", k), obj_count[k], 2);
    endtask

    task automatic t_empty(input int k, input int nl);
        start_pulse(k, nl, 0);
        @(negedge clk);
        check($sformatf("empty%0d c1 busy[%0d]", nl, k), busy[k], 1);
        check($sformatf("empty%0d c1 done[%0d]", nl, k), done[k], 0);
        check($sformatf("empty%0d c1 id[%0d]", nl, k), obj_id[k], 0);
        @(negedge clk);
        check($sformatf("empty%0d c2 done[%0d]", nl, k), done[k], 1);
        check($sformatf("empty%0d c2 busy[%0d]", nl, k), busy[k], 0);
        check($sformatf("empty%0d c2 count[%0d]", nl, k), obj_count[k], 0);
        check($sformatf("empty%0d c2 id[%0d]", nl, k), obj_id[k], 0);
        check($sformatf("empty%0d c2 valid[%0d]", nl, k), rec_valid[k], 0);
        @(negedge clk);
        check($sformatf("empty%0d c3 done[%0d]", nl, k), done[k], 0);
    endtask

    task automatic t_spacing(input int k);
        start_pulse(k, 6, 20);
        wait_done(k, 300);
        check($sformatf("all-emit count[%0d]", k), obj_count[k], 5);
    endtask

    task automatic t_repeat(input int k);
        int n  = 0;
        int d0 = done_cnt[k];
        head[k]    = 0;
        start_s[k] = 1'b1;
        nl_s[k]    = 8'd11;
        thr_s[k]   = 16'd7;
        @(posedge clk); #1;
        nl_s[k]  = 8'd3;
        thr_s[k] = 16'd0;
        while (n < 400) begin
            @(negedge clk);
            if (done[k]) break;
            n++;
        end
        if (n >= 400) fail($sformatf("repeat done[%0d]", k));
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("repeat idle busy %0d[%0d]", i, k), busy[k], 0);
        end
        check($sformatf("repeat single done[%0d]", k), done_cnt[k] - d0, 1);
        check($sformatf("repeat count held[%0d]", k), obj_count[k], 5);
        start_pulse(k, 11, 7);
        wait_done(k, 400);
        check($sformatf("repeat fresh count[%0d]", k), obj_count[k], 5);
    endtask

    task automatic t_max(input int k);
        start_pulse(k, 255, 100);
        wait_done(k, 3000);
        check($sformatf("max count[%0d]", k), obj_count[k], 6);
    endtask

    task automatic t_to_emit(input int k);
        start_pulse(k, 4, 5);
        wait_valid(k, 100);
    endtask

    task automatic clear_area();
        for (int i = 0; i < 256; i++) tbl_area[i] = 16'd0;
    endtask

    initial begin
        reset_n    = 1'b0;
        spacing_en = 1'b0;
        exp_n      = 0;
        exp_last   = 0;
        for (int k = 0; k < NI; k++) begin
            start_s[k] = 1'b0; nl_s[k] = 8'd0; thr_s[k] = 16'd0; rdy_s[k] = 1'b1;
            head[k] = 0; done_cnt[k] = 0; prev_stall[k] = 1'b0;
            last_cyc[k] = 0; last_lbl[k] = 0; prev_rec[k] = '0;
        end
        for (int i = 0; i < 256; i++) begin
            tbl_x[i] = 10'((i * 37 + 5) % 1024);
            tbl_y[i] = 10'((i * 53 + 11) % 1024);
        end
        tbl_x[0] = 10'h3FF;
        tbl_y[0] = 10'h3FF;
        clear_area();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst obj_id[%0d]", k), obj_id[k], 0);
            check($sformatf("rst valid[%0d]", k), rec_valid[k], 0);
            check($sformatf("rst rec[%0d]", k), cur_rec(k), 0);
            check($sformatf("rst busy[%0d]", k), busy[k], 0);
            check($sformatf("rst done[%0d]", k), done[k], 0);
            check($sformatf("rst count[%0d]", k), obj_count[k], 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Frame A: label 2 merged away, label 3 exactly at threshold
        tbl_area[1] = 16'd10; tbl_area[2] = 16'd0; tbl_area[3] = 16'd5;
        build_expected(4, 5);
        check("model A count", exp_n, 2);
        check("model A rec0 label", exp_list[0].label, 1);
        check("model A rec1 label", exp_list[1].label, 3);
        check("model A rec1 area", exp_list[1].area, 5);
        fork t_basic(0); t_basic(1); join
        @(posedge clk); #1;

        // Same frame with 7 cycles of backpressure on the first record
        rdy_s[0] = 1'b0; rdy_s[1] = 1'b0;
        fork t_bp(0); t_bp(1); join
        @(posedge clk); #1;

        // Empty sweeps
        for (int nl = 0; nl < 2; nl++) begin
            build_expected(nl, 0);
            fork t_empty(0, nl); t_empty(1, nl); join
            @(posedge clk); #1;
        end

        // Every label emitted: checks capture latency and per-label cadence
        clear_area();
        for (int id = 1; id <= 5; id++) tbl_area[id] = 16'(20 + id);
        build_expected(6, 20);
        check("model B count", exp_n, 5);
        spacing_en = 1'b1;
        fork t_spacing(0); t_spacing(1); join
        spacing_en = 1'b0;
        @(posedge clk); #1;

        // Ten labels, start held high for the whole sweep
        clear_area();
        tbl_area[1] = 16'd7;  tbl_area[2] = 16'd0;  tbl_area[3] = 16'd3;  tbl_area[4] = 16'd9;
        tbl_area[5] = 16'd7;  tbl_area[6] = 16'd6;  tbl_area[7] = 16'd12; tbl_area[8] = 16'd0;
        tbl_area[9] = 16'd8;  tbl_area[10] = 16'd1;
        build_expected(11, 7);
        check("model C count", exp_n, 5);
        fork t_repeat(0); t_repeat(1); join
        @(posedge clk); #1;

        // Full label range: last label is 254 and must be reported
        clear_area();
        for (int id = 1; id < 255; id++) tbl_area[id] = 16'(((id % 50) == 0) ? 100 : (id % 3));
        tbl_area[254] = 16'd100;
        build_expected(255, 100);
        check("model D count", exp_n, 6);
        check("model D last label", exp_list[5].label, 254);
        fork t_max(0); t_max(1); join
        @(posedge clk); #1;

        // Reset while a record is pending
        clear_area();
        tbl_area[1] = 16'd10; tbl_area[3] = 16'd5;
        build_expected(4, 5);
        rdy_s[0] = 1'b0; rdy_s[1] = 1'b0;
        fork t_to_emit(0); t_to_emit(1); join
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("async rst valid[%0d]", k), rec_valid[k], 0);
            check($sformatf("async rst busy[%0d]", k), busy[k], 0);
            check($sformatf("async rst done[%0d]", k), done[k], 0);
            check($sformatf("async rst id[%0d]", k), obj_id[k], 0);
            check($sformatf("async rst count[%0d]", k), obj_count[k], 0);
        end
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        rdy_s[0] = 1'b1; rdy_s[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                check($sformatf("post rst valid %0d[%0d]", i, k), rec_valid[k], 0);
                check($sformatf("post rst busy %0d[%0d]", i, k), busy[k], 0);
                check($sformatf("post rst id %0d[%0d]", i, k), obj_id[k], 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
